// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the master interface state type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;

  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;

  typedef enum logic [1:0] {
    AHBM_IDLE = 2'd0,
    AHBM_ADDR = 2'd1,
    AHBM_LAST = 2'd2,
    AHBM_DONE = 2'd3
  } ahbm_state_e;

endpackage

// File: rtl/ahb_master_beat_ctr.sv
// Beat bookkeeping for the AHB master: address/data phase counters,
// the address of the next beat and last-beat flags.
module ahb_master_beat_ctr
  import ahb_pkg::*;
#(
  parameter int unsigned MAX_BEATS = 4,
  parameter int unsigned CW        = $clog2(MAX_BEATS + 1)
) (
  input  logic          Hclk,
  input  logic          Hresetn,
  input  logic          start,
  input  logic [31:0]   start_addr,
  input  logic [CW-1:0] start_len,
  input  logic          addr_adv,
  input  logic          data_adv,
  output logic [CW-1:0] addr_cnt,
  output logic [CW-1:0] data_cnt,
  output logic [31:0]   next_addr_c,
  output logic          addr_last_c,
  output logic          data_last_c
);

  logic [CW-1:0] addr_cnt_q, addr_cnt_d;
  logic [CW-1:0] data_cnt_q, data_cnt_d;
  logic [CW-1:0] len_q, len_d;
  logic [31:0]   base_q, base_d;

  always_comb begin
    addr_cnt_d = addr_cnt_q;
    data_cnt_d = data_cnt_q;
    len_d      = len_q;
    base_d     = base_q;
    if (start) begin
      addr_cnt_d = '0;
      data_cnt_d = '0;
      len_d      = start_len;
      base_d     = start_addr;
    end else begin
      if (addr_adv) addr_cnt_d = addr_cnt_q + CW'(1);
      if (data_adv) data_cnt_d = data_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      addr_cnt_q <= '0;
      data_cnt_q <= '0;
      len_q      <= '0;
      base_q     <= '0;
    end else begin
      addr_cnt_q <= addr_cnt_d;
      data_cnt_q <= data_cnt_d;
      len_q      <= len_d;
      base_q     <= base_d;
    end
  end

  // Wraps at 32 bits; no 1KB boundary handling.
  assign next_addr_c = 32'(base_q + ((32'(addr_cnt_q) + 32'd1) << 2));
  assign addr_last_c = (addr_cnt_q == (len_q - CW'(1)));
  assign data_last_c = (data_cnt_q == (len_q - CW'(1)));
  assign addr_cnt    = addr_cnt_q;
  assign data_cnt    = data_cnt_q;

endmodule

// File: rtl/ahb_master_itfc.sv
// AHB-Lite initiator: turns one local command (single or INCR burst) into
// pipelined AHB phases. Define AHBM_ERR_ABORT_EN to abort bursts on ERROR.
module ahb_master_itfc
  import ahb_pkg::*;
#(
  parameter int unsigned MAX_BEATS = 4,
  parameter int unsigned DW        = 32
) (
  input  logic                    Hclk,
  input  logic                    Hresetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [31:0]             cmd_addr,
  input  logic [2:0]              cmd_len,
  input  logic [MAX_BEATS*DW-1:0] cmd_wdata,
  output logic                    rsp_valid,
  output logic [MAX_BEATS*DW-1:0] rsp_rdata,
  output logic                    rsp_err,
  output logic [31:0]             Haddr,
  output logic [1:0]              Htrans,
  output logic                    Hwrite,
  output logic [2:0]              Hsize,
  output logic [2:0]              Hburst,
  output logic [DW-1:0]           Hwdata,
  input  logic                    Hreadyout,
  input  logic [1:0]              Hresp,
  input  logic [DW-1:0]           Hrdata
);

  localparam int unsigned CW = $clog2(MAX_BEATS + 1);
  localparam int unsigned IW = $clog2(MAX_BEATS);
`ifdef AHBM_ERR_ABORT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  ahbm_state_e state_q, state_d;
  logic [1:0]  htrans_q, htrans_d;
  logic [31:0] haddr_q, haddr_d;
  logic        hwrite_q, hwrite_d;
  logic [2:0]  hburst_q, hburst_d;
  logic [DW-1:0] hwdata_q, hwdata_d;
  logic [MAX_BEATS-1:0][DW-1:0] wbuf_q, wbuf_d;
  logic [MAX_BEATS-1:0][DW-1:0] rdata_q, rdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic        cmd_ready_q, cmd_ready_d;

  logic [CW-1:0] len_eff_c;
  logic [31:0]   start_addr_c;
  logic          accept_c, addr_adv_c, dphase_c, data_adv_c, err_c;
  logic [CW-1:0] addr_cnt, data_cnt;
  logic [31:0]   next_addr_c;
  logic          addr_last_c, data_last_c;

  // Length 0 means one beat; oversize requests clamp to MAX_BEATS.
  always_comb begin
    if (cmd_len == 3'd0)                len_eff_c = CW'(1);
    else if (32'(cmd_len) > MAX_BEATS)  len_eff_c = CW'(MAX_BEATS);
    else                                len_eff_c = CW'(cmd_len);
  end

  assign start_addr_c = cmd_addr & 32'hFFFF_FFFC;
  assign accept_c     = cmd_valid && cmd_ready_q;
  assign addr_adv_c   = (state_q == AHBM_ADDR) && Hreadyout;
  assign dphase_c     = ((state_q == AHBM_ADDR) && (addr_cnt != '0)) || (state_q == AHBM_LAST);
  assign data_adv_c   = dphase_c && Hreadyout;
  assign err_c        = ERR_EN && data_adv_c && (Hresp == HRESP_ERROR);

  ahb_master_beat_ctr #(.MAX_BEATS(MAX_BEATS), .CW(CW)) u_beat_ctr (
    .Hclk        (Hclk),
    .Hresetn     (Hresetn),
    .start       (accept_c),
    .start_addr  (start_addr_c),
    .start_len   (len_eff_c),
    .addr_adv    (addr_adv_c),
    .data_adv    (data_adv_c),
    .addr_cnt    (addr_cnt),
    .data_cnt    (data_cnt),
    .next_addr_c (next_addr_c),
    .addr_last_c (addr_last_c),
    .data_last_c (data_last_c)
  );

  always_comb begin
    state_d     = state_q;
    htrans_d    = htrans_q;
    haddr_d     = haddr_q;
    hwrite_d    = hwrite_q;
    hburst_d    = hburst_q;
    hwdata_d    = hwdata_q;
    wbuf_d      = wbuf_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    cmd_ready_d = cmd_ready_q;

    if (data_adv_c && !hwrite_q) rdata_d[IW'(data_cnt)] = Hrdata;

    case (state_q)
      AHBM_IDLE: begin
        if (accept_c) begin
          state_d     = AHBM_ADDR;
          cmd_ready_d = 1'b0;
          htrans_d    = HTRANS_NONSEQ;
          haddr_d     = start_addr_c;
          hwrite_d    = cmd_write;
          wbuf_d      = cmd_wdata;
          if (len_eff_c == CW'(1))            hburst_d = HBURST_SINGLE;
          else if (32'(len_eff_c) == 32'd4)   hburst_d = HBURST_INCR4;
          else                                hburst_d = HBURST_INCR;
        end
      end
      AHBM_ADDR: begin
        // Write data follows its address phase by one cycle.
        if (addr_adv_c) begin
          hwdata_d = wbuf_q[IW'(addr_cnt)];
          if (addr_last_c) begin
            state_d  = AHBM_LAST;
            htrans_d = HTRANS_IDLE;
          end else begin
            htrans_d = HTRANS_SEQ;
            haddr_d  = next_addr_c;
          end
        end
        if (err_c) begin
          state_d     = AHBM_DONE;
          htrans_d    = HTRANS_IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end
      end
      AHBM_LAST: begin
        if (data_adv_c && data_last_c) begin
          state_d     = AHBM_DONE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = err_c;
        end
      end
      AHBM_DONE: begin
        state_d     = AHBM_IDLE;
        cmd_ready_d = 1'b1;
      end
      default: state_d = AHBM_IDLE;
    endcase
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q     <= AHBM_IDLE;
      htrans_q    <= HTRANS_IDLE;
      haddr_q     <= '0;
      hwrite_q    <= 1'b0;
      hburst_q    <= HBURST_SINGLE;
      hwdata_q    <= '0;
      wbuf_q      <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      htrans_q    <= htrans_d;
      haddr_q     <= haddr_d;
      hwrite_q    <= hwrite_d;
      hburst_q    <= hburst_d;
      hwdata_q    <= hwdata_d;
      wbuf_q      <= wbuf_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rdata_q;
  assign Haddr     = haddr_q;
  assign Htrans    = htrans_q;
  assign Hwrite    = hwrite_q;
  assign Hsize     = HSIZE_WORD;
  assign Hburst    = hburst_q;
  assign Hwdata    = hwdata_q;

endmodule

// File: tb/tb_ahb_master_itfc.sv
// Randomized bench for ahb_master_itfc: the bench plays the AHB slave and
// predicts every phase from the command, the wait states and the responses.
module tb_ahb_master_itfc;
  import ahb_pkg::*;

  localparam int unsigned MB = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned WW = MB * DW;
`ifdef AHBM_ERR_ABORT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          Hclk = 1'b0;
  logic          Hresetn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [31:0]   cmd_addr = '0;
  logic [2:0]    cmd_len = '0;
  logic [WW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic [WW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [31:0]   Haddr;
  logic [1:0]    Htrans;
  logic          Hwrite;
  logic [2:0]    Hsize;
  logic [2:0]    Hburst;
  logic [DW-1:0] Hwdata;
  logic          Hreadyout = 1'b1;
  logic [1:0]    Hresp = 2'b00;
  logic [DW-1:0] Hrdata = '0;

  int n_checks = 0;
  int n_errors = 0;
  logic [WW-1:0] exp_rdata = '0;

  always #5 Hclk = ~Hclk;

  ahb_master_itfc #(.MAX_BEATS(MB), .DW(DW)) dut (
    .Hclk(Hclk), .Hresetn(Hresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .Haddr(Haddr), .Htrans(Htrans), .Hwrite(Hwrite), .Hsize(Hsize),
    .Hburst(Hburst), .Hwdata(Hwdata), .Hreadyout(Hreadyout),
    .Hresp(Hresp), .Hrdata(Hrdata)
  );

  task automatic check(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int eff_len(input logic [2:0] l);
    if (l == 3'd0) return 1;
    if (int'(l) > int'(MB)) return int'(MB);
    return int'(l);
  endfunction

  function automatic logic [2:0] exp_burst(input int n);
    if (n == 1) return HBURST_SINGLE;
    if (n == 4) return HBURST_INCR4;
    return HBURST_INCR;
  endfunction

  function automatic logic [WW-1:0] rand_words();
    logic [WW-1:0] v;
    for (int i = 0; i < int'(MB); i++) v[i*DW +: DW] = $urandom;
    return v;
  endfunction

  // One command end to end; the bench answers as slave, injecting waits,
  // an optional ERROR on err_beat and an optional reset at rst_beat.
  task automatic run_cmd(input bit wr, input logic [31:0] addr, input logic [2:0] len,
                         input logic [WW-1:0] wdata, input int wait_pct,
                         input int wait_beat, input int wait_n, input int err_beat,
                         input int rst_beat, input bit fixed_rd);
    int n, ap, dp, waits, wleft, err_cyc, c;
    bit rdy, got_rsp, ap_active;
    logic [31:0] base, rd;
    n = eff_len(len); base = addr & 32'hFFFF_FFFC;
    ap = 0; dp = -1; waits = 0; wleft = wait_n; err_cyc = -1; c = 1; got_rsp = 1'b0;

    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len; cmd_wdata = wdata;
    @(posedge Hclk); #1;
    cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = $urandom;
    cmd_len = 3'($urandom_range(7)); cmd_wdata = rand_words();

    while (c <= 80) begin
      if (rsp_valid) begin
        got_rsp = 1'b1;
        check("rsp_latency", c, (err_cyc >= 0) ? err_cyc + 1 : 2 + n + waits);
        check("rsp_err", rsp_err, err_cyc >= 0);
        check("rsp_rdata", rsp_rdata, exp_rdata);
        check("htrans_at_rsp", Htrans, HTRANS_IDLE);
        break;
      end
      if (dp >= 0 && wr) check("hwdata", Hwdata, wdata[dp*DW +: DW]);
      ap_active = (Htrans != HTRANS_IDLE);
      if (ap_active) begin
        check("beat_in_range", ap < n, 1);
        check("haddr", Haddr, 32'(base + 32'(4 * ap)));
        check("htrans", Htrans, (ap == 0) ? HTRANS_NONSEQ : HTRANS_SEQ);
        check("hburst", Hburst, exp_burst(n));
        check("hwrite", Hwrite, wr);
        check("hsize", Hsize, HSIZE_WORD);
        if (ap == rst_beat) begin
          #2 Hresetn = 1'b0;
          #1;
          check("rst_htrans", Htrans, HTRANS_IDLE);
          check("rst_cmd_ready", cmd_ready, 1);
          check("rst_haddr", Haddr, 0);
          check("rst_rsp_valid", rsp_valid, 0);
          check("rst_rdata", rsp_rdata, 0);
          exp_rdata = '0;
          Hreadyout = 1'b1; Hresp = HRESP_OKAY;
          @(posedge Hclk); #2 Hresetn = 1'b1;
          for (int k = 0; k < 5; k++) begin
            @(posedge Hclk); #1;
            check("no_rsp_after_rst", rsp_valid, 0);
            check("idle_after_rst", Htrans, HTRANS_IDLE);
          end
          return;
        end
      end
      rdy = ($urandom_range(99) >= wait_pct);
      if (dp >= 0 && dp == wait_beat && wleft > 0) begin
        rdy = 1'b0;
        wleft--;
      end
      rd = fixed_rd ? 32'(32'h11 * (dp + 1)) : $urandom;
      Hreadyout = rdy; Hrdata = rd;
      Hresp = (dp >= 0 && dp == err_beat && rdy) ? HRESP_ERROR : HRESP_OKAY;
      @(posedge Hclk);
      if (rdy) begin
        if (dp >= 0) begin
          if (!wr) exp_rdata[dp*DW +: DW] = rd;
          if (dp == err_beat && ERR_EN) err_cyc = c;
        end
        if (ap_active) begin
          dp = ap;
          ap++;
        end else dp = -1;
      end else waits++;
      #1;
      c++;
    end
    if (!got_rsp) check("rsp_timeout", 0, 1);
    Hreadyout = 1'b1; Hresp = HRESP_OKAY;
    @(posedge Hclk); #1;
    check("rsp_one_cycle", rsp_valid, 0);
    check("cmd_ready_after", cmd_ready, 1);
    check("idle_after", Htrans, HTRANS_IDLE);
  endtask

  initial begin
    logic [WW-1:0] v;
    repeat (3) @(posedge Hclk);
    #1;
    check("reset_htrans", Htrans, HTRANS_IDLE);
    check("reset_haddr", Haddr, 0);
    check("reset_hwrite", Hwrite, 0);
    check("reset_hburst", Hburst, 0);
    check("reset_hwdata", Hwdata, 0);
    check("reset_cmd_ready", cmd_ready, 1);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_err", rsp_err, 0);
    check("reset_rsp_rdata", rsp_rdata, 0);
    Hresetn = 1'b1;
    @(posedge Hclk); #1;

    v = '0; v[31:0] = 32'hDEADBEEF;
    run_cmd(1'b1, 32'h8000_0010, 3'd1, v, 0, -1, 0, -1, -1, 1'b0);

    run_cmd(1'b0, 32'h8400_0000, 3'd4, '0, 0, -1, 0, -1, -1, 1'b1);
    v = {32'h44, 32'h33, 32'h22, 32'h11};
    check("incr4_rdata_const", rsp_rdata, v);

    run_cmd(1'b1, 32'h8000_0100, 3'd4, rand_words(), 0, 2, 2, -1, -1, 1'b0);
    run_cmd(1'b1, 32'h8000_0200, 3'd0, rand_words(), 0, -1, 0, -1, -1, 1'b0);
    run_cmd(1'b0, 32'h8000_0303, 3'd7, '0, 0, -1, 0, -1, -1, 1'b0);

    run_cmd(1'b1, 32'h8800_0000, 3'd4, rand_words(), 0, -1, 0, -1, 2, 1'b0);
    run_cmd(1'b0, 32'h8000_0040, 3'd2, '0, 0, -1, 0, -1, -1, 1'b0);

    run_cmd(1'b1, 32'h8000_0400, 3'd4, rand_words(), 0, -1, 0, 1, -1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_cmd(1'($urandom_range(1)), 32'h8000_0000 | ($urandom & 32'h03FF_FFFF),
              3'($urandom_range(7)), rand_words(), $urandom_range(40),
              -1, 0, -1, -1, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ahb_master_itfc.md
Name: ahb_master_itfc

Overview:
- AHB-Lite initiator that drives the AHB side of the AHB-to-APB bridge. It is the transmitter end of the interface the bridge's slave interface receives.
- Converts one local command (single or INCR burst of 1..MAX_BEATS word beats, read or write) into pipelined AHB address and data phases.
- Honours Hreadyout wait states and returns collected read data and a completion pulse.
- Used in the bridge testbench/SoC top as the bus initiator.

Parameters:
- MAX_BEATS, 4, maximum beats per command (burst length limit).
- DW, 32, data width; only 32 is supported.

Ports:
- Hclk  in  1  clock
- Hresetn  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE; command accepted on cmd_valid&&cmd_ready
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  32  start address; bits[1:0] ignored (forced 0)
- cmd_len  in  3  beat count; 0 treated as 1, >MAX_BEATS clamped to MAX_BEATS
- cmd_wdata  in  MAX_BEATS*DW  write data; beat n in bits[n*DW +: DW]
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  MAX_BEATS*DW  read data, beat n in [n*DW +: DW]; stable until next command accepted
- rsp_err  out  1  valid with rsp_valid (feature-dependent)
- Haddr  out  32  AHB address
- Htrans  out  2  IDLE=00, NONSEQ=10, SEQ=11 (BUSY=01 never driven)
- Hwrite  out  1  transfer direction
- Hsize  out  3  fixed 3'b010 (word)
- Hburst  out  3  SINGLE=000 for len 1, INCR4=011 for len 4, INCR=001 otherwise
- Hwdata  out  32  write data in data phase
- Hreadyout  in  1  slave ready / phase advance
- Hresp  in  2  slave response (OKAY=00, ERROR=01)
- Hrdata  in  32  read data

Behaviour:
- Reset (async, any time including mid-burst): state IDLE, Htrans=IDLE, Haddr=0, Hwrite=0, Hburst=0, Hwdata=0, beat counters=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, cmd_ready=1. No rsp_valid is generated for an aborted command.
- Command accept (IDLE, cycle T): latch cmd fields into an internal MAX_BEATS-word write buffer, length register and address register.
- FSM states:
  - IDLE: on accept, go to ADDR.
  - ADDR: address phases. Beat 0 drives Htrans=NONSEQ at T+1; later beats drive SEQ. Haddr = start + 4*beat.
  - LAST: data phase of the final beat only; Htrans=IDLE.
  - DONE: single cycle with rsp_valid=1; returns to IDLE.
- Phase advance: a phase (address or data) completes only at a rising edge with Hreadyout=1. With Hreadyout=0, Haddr, Htrans, Hwrite and Hwdata hold unchanged.
- Pipelining: the data phase of beat n overlaps the address phase of beat n+1.
  - Hwdata is registered and shows buffer[n] in the cycle after beat n's address phase completes.
  - Read data is captured as rsp_rdata[n] <= Hrdata at the edge where beat n's data phase completes.
- Transitions: after the last address phase completes, ADDR goes to LAST. When the last data phase completes, LAST goes to DONE.
- Zero-wait latency: single write, accept at T gives NONSEQ at T+1, Hwdata at T+2, rsp_valid at T+3. A 4-beat burst gives rsp_valid at T+6. Each wait cycle adds 1.
- Hwrite and Hburst are constant for a command. Htrans returns to IDLE between commands, with at least one IDLE cycle.
- Address increment is 32-bit wrap-around with no 1KB-boundary check. Callers must keep bursts inside the bridge window 0x8000_0000..0x8BFF_FFFF.
- Unused upper rsp_rdata words, and all words for writes, retain their previous values.

Optional Feature:
- Macro: AHBM_ERR_ABORT_EN.
- Enabled:
  - Hresp=ERROR sampled at a data-phase completion marks the command errored.
  - If an address phase is pending, the master drives Htrans=IDLE for the remaining beats, ends the burst and goes to DONE.
  - rsp_err=1 with rsp_valid.
- Disabled: Hresp is ignored, all beats complete, and rsp_err is tied 0.

Decomposition:
- Package ahb_pkg holds:
  - HTRANS_IDLE/NONSEQ/SEQ constants
  - HBURST_SINGLE/INCR/INCR4 constants
  - HSIZE_WORD constant
  - HRESP_OKAY/ERROR constants
  - master FSM state typedef
- One sub-module, ahb_master_beat_ctr: address-phase and data-phase beat counters, current address, and last-beat flags.

Test Plan:
- Single write, addr 0x8000_0010, data 0xDEADBEEF, Hreadyout=1:
  - Htrans=10 at T+1, Haddr=0x8000_0010, Hburst=000
  - Hwdata=0xDEADBEEF at T+2; rsp_valid at T+3
- INCR4 read from 0x8400_0000, Hrdata=0x11,0x22,0x33,0x44:
  - Htrans sequence 10,11,11,11,00; Haddr +4 each beat; Hburst=011
  - rsp_rdata={0x44,0x33,0x22,0x11}; rsp_valid at T+6
- INCR4 write with Hreadyout low for 2 cycles during beat 2 data phase:
  - Haddr, Htrans and Hwdata hold during the wait; rsp_valid at T+8; no beat duplicated or skipped.
- cmd_len=0 and cmd_len=7:
  - length 0 gives 1 beat with SINGLE burst
  - length 7 gives 4 beats with INCR4 burst
- Hresetn asserted mid-burst (beat 2):
  - immediately Htrans=00 and cmd_ready=1; no rsp_valid
  - the next command starts cleanly with NONSEQ
- With AHBM_ERR_ABORT_EN, ERROR on beat 1 of 4: Htrans=00 from then on; rsp_valid with rsp_err=1. Without the macro, all 4 beats complete and rsp_err=0.
